// File: rtl/filter_seq.sv
// filter_seq: control sequencer for the FIR filter datapath.
//
// Accepts one input sample at a time over a req/gnt handshake and writes it
// into a circular delay line held in an external sample RAM. For each sample
// it steps through Order+1 taps, driving the sample read address, the
// coefficient address and the MAC strobes. It then waits MacLatency cycles
// for the MAC pipeline to drain and holds a result request until the
// consumer grants it. After reset the whole delay line is zeroed before the
// first sample is accepted.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   data_in_req_i/gnt_o/data_in_i upstream sample handshake and data
//   smp_we_o/waddr_o/wdata_o      sample RAM write port
//   smp_raddr_o                   sample RAM read address for the current tap
//   coef_raddr_o                  coefficient ROM address (tap index)
//   mac_en_o, mac_clr_o           MAC accumulate strobe / load-instead-of-add
//   data_out_req_o/gnt_i          result handshake
//   busy_o                        high whenever the sequencer is not idle
module filter_seq #(
  parameter int Order      = 127,
  parameter int AddrWidth  = 7,
  parameter int DataWidth  = 16,
  parameter int MacLatency = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 data_in_req_i,
  output logic                 data_in_gnt_o,
  input  logic [DataWidth-1:0] data_in_i,
  output logic                 smp_we_o,
  output logic [AddrWidth-1:0] smp_waddr_o,
  output logic [DataWidth-1:0] smp_wdata_o,
  output logic [AddrWidth-1:0] smp_raddr_o,
  output logic [AddrWidth-1:0] coef_raddr_o,
  output logic                 mac_en_o,
  output logic                 mac_clr_o,
  output logic                 data_out_req_o,
  input  logic                 data_out_gnt_i,
  output logic                 busy_o
);

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } state_e;

  localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(Order);
  localparam logic [AddrWidth-1:0] One     = AddrWidth'(1);
  // One extra bit so newest+N-k can be formed without overflow before it is
  // truncated back to an address.
  localparam logic [AddrWidth:0]   NumTaps = (AddrWidth+1)'(Order + 1);

  // The drain counter only needs to reach MacLatency-1; keep it at least one
  // bit wide so the declaration stays legal when MacLatency is 0 or 1.
  localparam int                DrainW    = (MacLatency > 1) ? $clog2(MacLatency) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'((MacLatency > 0) ? MacLatency - 1 : 0);

  state_e                 state_q, state_d;
  logic [AddrWidth-1:0]   counter_q, counter_d;
  logic [AddrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0]   newest_q, newest_d;
  logic [DrainW-1:0]      drain_q, drain_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= CLEAR;
      counter_q <= '0;
      wr_ptr_q  <= '0;
      newest_q  <= '0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      wr_ptr_q  <= wr_ptr_d;
      newest_q  <= newest_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    counter_d      = counter_q;
    wr_ptr_d       = wr_ptr_q;
    newest_d       = newest_q;
    drain_d        = drain_q;
    data_in_gnt_o  = 1'b0;
    smp_we_o       = 1'b0;
    smp_waddr_o    = '0;
    smp_wdata_o    = '0;
    smp_raddr_o    = '0;
    coef_raddr_o   = '0;
    mac_en_o       = 1'b0;
    mac_clr_o      = 1'b0;
    data_out_req_o = 1'b0;
    busy_o         = 1'b1;

    case (state_q)
      CLEAR: begin
        smp_we_o    = 1'b1;
        smp_waddr_o = counter_q;
        if (counter_q == LastIdx) begin
          counter_d = '0;
          state_d   = IDLE;
        end else begin
          counter_d = counter_q + One;
        end
      end

      IDLE: begin
        busy_o        = 1'b0;
        // Grant is a pure state decode, so req alone completes the handshake.
        data_in_gnt_o = 1'b1;
        if (data_in_req_i) begin
          smp_we_o    = 1'b1;
          smp_waddr_o = wr_ptr_q;
          smp_wdata_o = data_in_i;
          newest_d    = wr_ptr_q;
          wr_ptr_d    = (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + One;
          counter_d   = '0;
          state_d     = MAC;
        end
      end

      MAC: begin
        mac_en_o     = 1'b1;
        mac_clr_o    = (counter_q == '0);
        coef_raddr_o = counter_q;
        // Walk backwards from the newest sample; wrap by adding N explicitly
        // so non-power-of-two delay lines never touch addresses >= N.
        if (newest_q >= counter_q) begin
          smp_raddr_o = newest_q - counter_q;
        end else begin
          smp_raddr_o = AddrWidth'({1'b0, newest_q} + NumTaps - {1'b0, counter_q});
        end
        if (counter_q == LastIdx) begin
          counter_d = '0;
          drain_d   = '0;
          state_d   = (MacLatency == 0) ? OUT : DRAIN;
        end else begin
          counter_d = counter_q + One;
        end
      end

      DRAIN: begin
        if (drain_q == DrainLast) begin
          drain_d = '0;
          state_d = OUT;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end

      OUT: begin
        data_out_req_o = 1'b1;
        if (data_out_gnt_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

endmodule

// File: tb/tb_filter_seq.sv
// tb_filter_seq: scoreboard bench for filter_seq.
//
// Instance A uses Order=3, AddrWidth=2, MacLatency=2; instance B uses
// Order=4, AddrWidth=3 (non-power-of-two delay line). Stimulus tasks push the
// hand-derived sample RAM writes, per-tap MAC address tuples and the cycle in
// which the result request should rise; monitors pop and compare whenever the
// DUT presents a write strobe, a MAC strobe or a rising result request.
module tb_filter_seq;

  logic        clk;
  logic        rst_n;
  logic        rst_nb;
  int          cyc;

  logic        req_a, gnt_a, we_a, mac_en_a, mac_clr_a, oreq_a, ognt_a, busy_a;
  logic [15:0] din_a, wdata_a;
  logic [1:0]  waddr_a, raddr_a, coef_a;

  logic        req_b, gnt_b, we_b, mac_en_b, mac_clr_b, oreq_b, ognt_b, busy_b;
  logic [15:0] din_b, wdata_b;
  logic [2:0]  waddr_b, raddr_b, coef_b;

  logic        oreq_a_prev, oreq_b_prev;

  logic [31:0] exp_wr_a[$], exp_mac_a[$], exp_out_a[$];
  logic [31:0] exp_wr_b[$], exp_mac_b[$], exp_out_b[$];

  int          vectors;
  int          miscompares;
  int          wr_ptr_a, wr_ptr_b;
  int          hs_a;

  filter_seq #(.Order(3), .AddrWidth(2), .DataWidth(16), .MacLatency(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .data_in_req_i(req_a), .data_in_gnt_o(gnt_a), .data_in_i(din_a),
    .smp_we_o(we_a), .smp_waddr_o(waddr_a), .smp_wdata_o(wdata_a),
    .smp_raddr_o(raddr_a), .coef_raddr_o(coef_a),
    .mac_en_o(mac_en_a), .mac_clr_o(mac_clr_a),
    .data_out_req_o(oreq_a), .data_out_gnt_i(ognt_a), .busy_o(busy_a)
  );

  filter_seq #(.Order(4), .AddrWidth(3), .DataWidth(16), .MacLatency(2)) dut_b (
    .clk_i(clk), .rst_ni(rst_nb),
    .data_in_req_i(req_b), .data_in_gnt_o(gnt_b), .data_in_i(din_b),
    .smp_we_o(we_b), .smp_waddr_o(waddr_b), .smp_wdata_o(wdata_b),
    .smp_raddr_o(raddr_b), .coef_raddr_o(coef_b),
    .mac_en_o(mac_en_b), .mac_clr_o(mac_clr_b),
    .data_out_req_o(oreq_b), .data_out_gnt_i(ognt_b), .busy_o(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for instance A: every presented strobe must match the oldest
  // outstanding expectation of its kind.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we_a) begin
        if (exp_wr_a.size() == 0) checkOutput("wr_a_unexpected", 32'({waddr_a, wdata_a}), 32'hFFFF_FFFF);
        else                      checkOutput("wr_a", 32'({waddr_a, wdata_a}), exp_wr_a.pop_front());
      end
      if (mac_en_a) begin
        if (exp_mac_a.size() == 0) checkOutput("mac_a_unexpected", 32'({raddr_a, coef_a, mac_clr_a}), 32'hFFFF_FFFF);
        else                       checkOutput("mac_a", 32'({raddr_a, coef_a, mac_clr_a}), exp_mac_a.pop_front());
      end
      if (oreq_a && !oreq_a_prev) begin
        if (exp_out_a.size() == 0) checkOutput("out_a_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else                       checkOutput("out_a_cycle", 32'(cyc), exp_out_a.pop_front());
      end
      oreq_a_prev <= oreq_a;
    end else begin
      oreq_a_prev <= 1'b0;
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (rst_nb) begin
      if (we_b) begin
        if (exp_wr_b.size() == 0) checkOutput("wr_b_unexpected", 32'({waddr_b, wdata_b}), 32'hFFFF_FFFF);
        else                      checkOutput("wr_b", 32'({waddr_b, wdata_b}), exp_wr_b.pop_front());
      end
      if (mac_en_b) begin
        if (exp_mac_b.size() == 0) checkOutput("mac_b_unexpected", 32'({raddr_b, coef_b, mac_clr_b}), 32'hFFFF_FFFF);
        else                       checkOutput("mac_b", 32'({raddr_b, coef_b, mac_clr_b}), exp_mac_b.pop_front());
      end
      if (oreq_b && !oreq_b_prev) begin
        if (exp_out_b.size() == 0) checkOutput("out_b_unexpected", 32'(cyc), 32'hFFFF_FFFF);
        else                       checkOutput("out_b_cycle", 32'(cyc), exp_out_b.pop_front());
      end
      oreq_b_prev <= oreq_b;
    end else begin
      oreq_b_prev <= 1'b0;
    end
  end

  // Issue one sample to A. Expectations are queued before the handshake so
  // the monitor never sees a strobe ahead of its expectation.
  task automatic applyStimulus(input logic [15:0] s);
    int waited;
    int r;
    @(posedge clk); #1;
    din_a = s;
    req_a = 1'b1;
    exp_wr_a.push_back(32'((wr_ptr_a << 16) | int'(s)));
    for (int k = 0; k < 4; k++) begin
      r = (wr_ptr_a - k + 4) % 4;
      exp_mac_a.push_back(32'((r << 3) | (k << 1) | ((k == 0) ? 1 : 0)));
    end
    waited = 0;
    @(negedge clk);
    while (!gnt_a && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!gnt_a) begin
      checkOutput("gnt_a_timeout", 32'(gnt_a), 32'd1);
      req_a = 1'b0;
      return;
    end
    hs_a = cyc;
    exp_out_a.push_back(32'(cyc + 7));
    wr_ptr_a = (wr_ptr_a + 1) % 4;
    @(posedge clk); #1;
    req_a = 1'b0;
  endtask

  task automatic applyStimulusB(input logic [15:0] s);
    int waited;
    int r;
    @(posedge clk); #1;
    din_b = s;
    req_b = 1'b1;
    exp_wr_b.push_back(32'((wr_ptr_b << 16) | int'(s)));
    for (int k = 0; k < 5; k++) begin
      r = (wr_ptr_b - k + 5) % 5;
      exp_mac_b.push_back(32'((r << 4) | (k << 1) | ((k == 0) ? 1 : 0)));
    end
    waited = 0;
    @(negedge clk);
    while (!gnt_b && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (!gnt_b) begin
      checkOutput("gnt_b_timeout", 32'(gnt_b), 32'd1);
      req_b = 1'b0;
      return;
    end
    exp_out_b.push_back(32'(cyc + 8));
    wr_ptr_b = (wr_ptr_b + 1) % 5;
    @(posedge clk); #1;
    req_b = 1'b0;
  endtask

  task automatic waitIdleA();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!gnt_a && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_a_reached", 32'(gnt_a), 32'd1);
  endtask

  task automatic waitIdleB();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!gnt_b && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("idle_b_reached", 32'(gnt_b), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    wr_ptr_a    = 0;
    wr_ptr_b    = 0;
    hs_a        = 0;
    rst_n  = 1'b0;
    rst_nb = 1'b0;
    req_a  = 1'b0; din_a = '0; ognt_a = 1'b1;
    req_b  = 1'b0; din_b = '0; ognt_b = 1'b1;
    for (int i = 0; i < 4; i++) exp_wr_a.push_back(32'(i << 16));
    for (int i = 0; i < 5; i++) exp_wr_b.push_back(32'(i << 16));

    // Reset values while held in reset.
    #3;
    checkOutput("rst_we",    32'(we_a),     32'd1);
    checkOutput("rst_waddr", 32'(waddr_a),  32'd0);
    checkOutput("rst_busy",  32'(busy_a),   32'd1);
    checkOutput("rst_gnt",   32'(gnt_a),    32'd0);
    checkOutput("rst_oreq",  32'(oreq_a),   32'd0);
    checkOutput("rst_mac",   32'(mac_en_a), 32'd0);

    // Release just after an edge so the first CLEAR write is sampled.
    @(posedge clk); #1;
    rst_n  = 1'b1;
    rst_nb = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("clear_last_gnt",  32'(gnt_a),  32'd0);
    checkOutput("clear_last_busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    checkOutput("clear_done_gnt",  32'(gnt_a),  32'd1);
    checkOutput("clear_done_busy", 32'(busy_a), 32'd0);
    checkOutput("clear_writes_left", 32'(exp_wr_a.size()), 32'd0);

    // Single sample, immediate output grant.
    applyStimulus(16'h0005);
    waitIdleA();

    // Output stall: result held, no new sample accepted while req is high.
    ognt_a = 1'b0;
    applyStimulus(16'h00AA);
    waited = 0;
    @(negedge clk);
    while (!oreq_a && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("stall_oreq_rise", 32'(oreq_a), 32'd1);
    @(posedge clk); #1;
    req_a = 1'b1;
    din_a = 16'h0BBB;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("stall_oreq", 32'(oreq_a),   32'd1);
      checkOutput("stall_gnt",  32'(gnt_a),    32'd0);
      checkOutput("stall_mac",  32'(mac_en_a), 32'd0);
    end
    @(posedge clk); #1;
    req_a  = 1'b0;
    ognt_a = 1'b1;
    @(negedge clk);
    checkOutput("release_oreq_held", 32'(oreq_a), 32'd1);
    @(negedge clk);
    checkOutput("release_oreq_drop", 32'(oreq_a), 32'd0);
    checkOutput("release_idle_gnt",  32'(gnt_a),  32'd1);
    checkOutput("release_idle_busy", 32'(busy_a), 32'd0);

    // Asynchronous reset during MAC tap 2.
    applyStimulus(16'h0077);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_mac",   32'(mac_en_a), 32'd0);
    checkOutput("abort_we",    32'(we_a),     32'd1);
    checkOutput("abort_waddr", 32'(waddr_a),  32'd0);
    checkOutput("abort_busy",  32'(busy_a),   32'd1);
    checkOutput("abort_oreq",  32'(oreq_a),   32'd0);
    exp_mac_a.delete();
    exp_out_a.delete();
    wr_ptr_a = 0;
    for (int i = 0; i < 4; i++) exp_wr_a.push_back(32'(i << 16));
    @(posedge clk); #1;
    rst_n = 1'b1;
    waitIdleA();

    // Six back-to-back samples: pointer wraps and one sample per 8 cycles.
    for (int i = 0; i < 6; i++) begin
      int prev_hs;
      prev_hs = hs_a;
      applyStimulus(16'h0011 + 16'(i));
      if (i > 0) checkOutput("b2b_period", 32'(hs_a - prev_hs), 32'd8);
    end
    waitIdleA();

    // Non-power-of-two delay line: pointer wraps 4->0.
    for (int i = 0; i < 7; i++) applyStimulusB(16'h0100 + 16'(i));
    waitIdleB();

    checkOutput("left_wr_a",  32'(exp_wr_a.size()),  32'd0);
    checkOutput("left_mac_a", 32'(exp_mac_a.size()), 32'd0);
    checkOutput("left_out_a", 32'(exp_out_a.size()), 32'd0);
    checkOutput("left_wr_b",  32'(exp_wr_b.size()),  32'd0);
    checkOutput("left_mac_b", 32'(exp_mac_b.size()), 32'd0);
    checkOutput("left_out_b", 32'(exp_out_b.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/filter_seq.md
Name: filter_seq

Overview:
- Sequencer for the FIR filter datapath: accepts input samples over a req/gnt handshake and manages the circular sample delay line.
- Per sample, issues Order+1 tap iterations (sample address, coefficient address, MAC enable/clear), waits for the MAC pipeline to drain, then presents the result handshake.
- Sits between the upstream sample source and the filter's sample RAM, coefficient ROM and MAC; holds no arithmetic datapath itself.

Parameters:
- Order, 127, filter order; taps N = Order+1; delay line depth N.
- AddrWidth, 7, width of sample and coefficient addresses; must satisfy 2**AddrWidth >= N.
- DataWidth, 16, sample width.
- MacLatency, 2, cycles from last mac_en_o to valid accumulator result (>=0).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_in_req_i  in  1  input sample request.
- data_in_gnt_o  out  1  input sample grant.
- data_in_i  in  DataWidth  input sample.
- smp_we_o  out  1  sample RAM write enable.
- smp_waddr_o  out  AddrWidth  sample RAM write address.
- smp_wdata_o  out  DataWidth  sample RAM write data.
- smp_raddr_o  out  AddrWidth  sample RAM read address.
- coef_raddr_o  out  AddrWidth  coefficient read address (tap index).
- mac_en_o  out  1  MAC accumulate strobe, aligned with read addresses.
- mac_clr_o  out  1  with mac_en_o: accumulator loads product instead of adding.
- data_out_req_o  out  1  result valid request.
- data_out_gnt_i  in  1  result accepted.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- One clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values: state=CLEAR, counter=0, wr_ptr=0, newest=0. All outputs are 0 except smp_we_o=1 and busy_o=1, which follow CLEAR decode.
- FSM states: CLEAR, IDLE, MAC, DRAIN, OUT.
- CLEAR:
  - One write per cycle: smp_we_o=1, smp_waddr_o=counter, smp_wdata_o=0.
  - Runs N cycles, counter 0..Order, then goes to IDLE with counter=0.
  - data_in_gnt_o=0 throughout.
- IDLE:
  - data_in_gnt_o=1 (state decode only; must not depend on req).
  - Handshake = req & gnt. In the handshake cycle, combinationally: smp_we_o=1, smp_waddr_o=wr_ptr, smp_wdata_o=data_in_i.
  - Registered on handshake: newest<=wr_ptr; wr_ptr<=(wr_ptr==Order)?0:wr_ptr+1; counter<=0; state->MAC.
  - Without req: remain in IDLE, all strobes 0.
- MAC:
  - Runs N cycles, k=counter=0..Order.
  - mac_en_o=1; mac_clr_o=(k==0); coef_raddr_o=k.
  - smp_raddr_o=(newest-k) mod N. When newest<k, add N explicitly; wrapping to 2**AddrWidth is not permitted unless N is a power of two.
  - After k==Order: counter<=0; state->DRAIN, or ->OUT if MacLatency==0.
- DRAIN: MacLatency cycles, all strobes 0, then ->OUT.
- OUT:
  - data_out_req_o=1, held stable until data_out_gnt_i=1.
  - A grant in the same cycle that req rises completes immediately. Completion ->IDLE.
  - data_in_gnt_o=0 in every state except IDLE, so a new sample is never accepted until the result is taken.
- Latency: handshake in cycle t, first mac_en_o in t+1, last in t+N, data_out_req_o first high in t+N+1+MacLatency. Order=127, MacLatency=2: t+131.
- Throughput: one sample per N+2+MacLatency cycles when the output grant is immediate.
- data_out_gnt_i outside OUT is ignored.
- Reset asserted in any state (mid-MAC, mid-OUT): immediately abort to CLEAR. Outstanding data_out_req_o drops with no result delivered; the delay line is re-zeroed.
- Unused address bits above log2(N) stay 0.

Test Plan (Order=3, AddrWidth=2, MacLatency=2 unless noted):
- Reset release -> smp_we_o high 4 cycles, waddr 0,1,2,3, wdata 0; data_in_gnt_o rises the cycle after the last write; busy_o falls with it.
- Single sample 0x0005 with req held -> write at addr 0 in the handshake cycle; smp_raddr_o 0,3,2,1; coef_raddr_o 0,1,2,3; mac_clr_o only on the first; data_out_req_o rises 7 cycles after the handshake.
- Six back-to-back samples, gnt_i tied high -> write addresses 0,1,2,3,0,1. Sixth sample reads 1,0,3,2. One accepted sample per 8 cycles.
- data_out_gnt_i held low 10 cycles in OUT -> data_out_req_o stays high, data_in_gnt_o stays 0 with data_in_req_i high, no MAC strobes; release -> IDLE next cycle.
- Order=4, AddrWidth=3 (non-power-of-two N=5), 7 samples -> write pointer wraps 4->0, never emits 5..7; read sequence for newest=1 is 1,0,4,3,2.
- rst_ni pulsed low asynchronously during MAC tap 2 -> outputs reset without a clock edge; CLEAR re-runs; the next sample is written to address 0.
